// File: rtl/rslatch_seq_pkg.sv
// -----------------------------------------------------------------------------
// rslatch_seq_pkg
// Shared types for the RS-latch sequencing controller.
//   op_e    : command operation encodings carried on cmd_op.
//   state_e : controller FSM states (also exported on the debug port).
//   max_int : helper used to size the shared pulse/settle counter.
// -----------------------------------------------------------------------------
package rslatch_seq_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_SET    = 2'b01,
        OP_CLR    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        APPLY  = 3'd2,
        SETTLE = 3'd3,
        CHECK  = 3'd4,
        RESP   = 3'd5
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rslatch_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// rslatch_seq_ctrl_if
// Command/response bus between the register logic (master) and the latch
// sequencing controller (slave).
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  controller can accept a command
//   cmd_idx    master->slave  target latch index (IDX_W bits)
//   cmd_op     master->slave  operation (see rslatch_seq_pkg::op_e)
//   rsp_valid  slave->master  one-cycle response strobe
//   rsp_ok     slave->master  readback matched the expected value
//   rsp_q      slave->master  q sampled at readback, held until next response
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both 1. cmd_idx/cmd_op must be stable while cmd_valid is high,
// and the master keeps cmd_valid asserted until that transfer happens.
// cmd_valid while cmd_ready is 0 is ignored. rsp_valid has no back-pressure.
// -----------------------------------------------------------------------------
interface rslatch_seq_ctrl_if #(
    parameter int IDX_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [IDX_W-1:0] cmd_idx;
    logic [1:0]       cmd_op;
    logic             rsp_valid;
    logic             rsp_ok;
    logic             rsp_q;

    modport master (
        output cmd_valid, cmd_idx, cmd_op,
        input  cmd_ready, rsp_valid, rsp_ok, rsp_q
    );

    modport slave (
        input  cmd_valid, cmd_idx, cmd_op,
        output cmd_ready, rsp_valid, rsp_ok, rsp_q
    );
endinterface

// File: rtl/rslatch_seq_drv.sv
// -----------------------------------------------------------------------------
// rslatch_seq_drv
// Registered set/reset line driver for the latch bank.
//   clk, rst  : clock and synchronous active-high reset
//   idx       : latch to drive
//   set, clr  : which line to pulse (set wins if both are presented)
//   active    : drive the one-hot s or r line next cycle
//   clr_all   : drive every r line next cycle (bank initialisation)
//   latch_s   : registered per-latch set lines
//   latch_r   : registered per-latch reset lines
//   latch_en  : bank enable, 0 in reset and 1 afterwards
// The s and r masks are derived from mutually exclusive terms, so no bit can
// ever have both lines high.
// -----------------------------------------------------------------------------
module rslatch_seq_drv #(
    parameter int NUM_LATCH = 8,
    parameter int IDX_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     idx,
    input  logic                 set,
    input  logic                 clr,
    input  logic                 active,
    input  logic                 clr_all,
    output logic [NUM_LATCH-1:0] latch_s,
    output logic [NUM_LATCH-1:0] latch_r,
    output logic                 latch_en
);

    localparam logic [NUM_LATCH-1:0] ONE = {{(NUM_LATCH-1){1'b0}}, 1'b1};

    logic [NUM_LATCH-1:0] onehot;
    logic [NUM_LATCH-1:0] s_next;
    logic [NUM_LATCH-1:0] r_next;

    // Out-of-range indices shift the single 1 off the top and give an empty mask.
    assign onehot = ONE << idx;

    always_comb begin
        s_next = '0;
        r_next = '0;
        if (clr_all) begin
            r_next = '1;
        end else if (active && set) begin
            s_next = onehot;
        end else if (active && clr) begin
            r_next = onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            latch_s  <= '0;
            latch_r  <= '0;
            latch_en <= 1'b0;
        end else begin
            latch_s  <= s_next;
            latch_r  <= r_next;
            latch_en <= 1'b1;
        end
    end

    a_no_sr_overlap : assert property (@(posedge clk) (latch_s & latch_r) == '0);

endmodule

// File: rtl/rslatch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rslatch_seq_ctrl
// Sequences SET/CLR/TOGGLE commands onto a bank of external RS latches:
// pulse s or r for PULSE_CYC cycles, hold both low for SETTLE_CYC cycles,
// read q/nq back and report pass/fail. After reset every latch is cleared.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : command/response interface (slave side)
//   latch_s/r  : per-latch set/reset lines (registered, never both high)
//   latch_en   : bank enable
//   latch_q/nq : latch readback
//   dbg_state  : current FSM state
// Optional build macro RSLATCH_SEQ_RETRY_EN: a failed readback re-runs the
// pulse/settle/check sequence once with the same op; the second result is
// reported.
// -----------------------------------------------------------------------------
module rslatch_seq_ctrl
    import rslatch_seq_pkg::*;
#(
    parameter int NUM_LATCH  = 8,
    parameter int IDX_W      = 3,
    parameter int PULSE_CYC  = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    rslatch_seq_ctrl_if.slave    bus,
    output logic [NUM_LATCH-1:0] latch_s,
    output logic [NUM_LATCH-1:0] latch_r,
    output logic                 latch_en,
    input  logic [NUM_LATCH-1:0] latch_q,
    input  logic [NUM_LATCH-1:0] latch_nq,
    output state_e               dbg_state
);

    localparam int CNT_W = $clog2(max_int(PULSE_CYC, SETTLE_CYC) + 1);
    localparam logic [NUM_LATCH-1:0] ONE = {{(NUM_LATCH-1){1'b0}}, 1'b1};

    state_e             state;
    state_e             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               in_init;     // SETTLE belongs to the post-reset clear
    logic [IDX_W-1:0]   idx_q;
    logic               set_q;       // resolved op: 1 = SET, 0 = CLR
    logic               rsp_ok_q;
    logic               rsp_q_q;
`ifdef RSLATCH_SEQ_RETRY_EN
    logic               retry_q;
`endif

    logic               cmd_bad;
    logic               cmd_nop;
    logic               q_at_cmd;
    logic               set_now;
    logic               q_sel;
    logic               nq_sel;
    logic               check_ok;

    logic [IDX_W-1:0]   drv_idx;
    logic               drv_set;
    logic               drv_active;
    logic               drv_clr_all;

    assign cmd_bad  = 32'(bus.cmd_idx) >= 32'(NUM_LATCH);
    assign cmd_nop  = (op_e'(bus.cmd_op) == OP_NOP);
    assign q_at_cmd = |(latch_q & (ONE << bus.cmd_idx));
    // TOGGLE becomes SET when the addressed latch currently reads 0.
    assign set_now  = (op_e'(bus.cmd_op) == OP_SET) ||
                      ((op_e'(bus.cmd_op) == OP_TOGGLE) && !q_at_cmd);
    assign q_sel    = |(latch_q  & (ONE << idx_q));
    assign nq_sel   = |(latch_nq & (ONE << idx_q));
    assign check_ok = (q_sel == set_q) && (nq_sel != q_sel);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            INIT: begin
                // One lead cycle while the registered r lines come up, then
                // PULSE_CYC cycles of r driven.
                if (cnt == '0) state_next = SETTLE;
            end
            IDLE: begin
                if (bus.cmd_valid) state_next = (cmd_bad || cmd_nop) ? RESP : APPLY;
            end
            APPLY: begin
                if (cnt == CNT_W'(1)) state_next = SETTLE;
            end
            SETTLE: begin
                if (cnt == CNT_W'(1)) state_next = in_init ? IDLE : CHECK;
            end
            CHECK: begin
`ifdef RSLATCH_SEQ_RETRY_EN
                state_next = (!check_ok && !retry_q) ? APPLY : RESP;
`else
                state_next = RESP;
`endif
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // Output logic. Line drive requests look at the next state because the
    // driver registers them, so s/r are high exactly while the FSM is in APPLY.
    always_comb begin
        bus.cmd_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
        bus.rsp_ok    = rsp_ok_q;
        bus.rsp_q     = rsp_q_q;
        drv_active    = (state_next == APPLY);
        drv_clr_all   = (state_next == INIT);
        drv_idx       = (state == IDLE) ? bus.cmd_idx : idx_q;
        drv_set       = (state == IDLE) ? set_now : set_q;
        dbg_state     = state;
    end

    // Counter and captured command/response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= CNT_W'(PULSE_CYC);
            in_init  <= 1'b1;
            idx_q    <= '0;
            set_q    <= 1'b0;
            rsp_ok_q <= 1'b0;
            rsp_q_q  <= 1'b0;
        end else begin
            if (state_next == APPLY && state != APPLY) begin
                cnt <= CNT_W'(PULSE_CYC);
            end else if (state_next == SETTLE && state != SETTLE) begin
                cnt <= CNT_W'(SETTLE_CYC);
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (state == IDLE && bus.cmd_valid) begin
                idx_q <= bus.cmd_idx;
                set_q <= set_now;
                // Immediate responses: bad index fails, NOP succeeds.
                if (cmd_bad || cmd_nop) rsp_ok_q <= !cmd_bad;
            end

            if (state == CHECK && state_next == RESP) begin
                rsp_ok_q <= check_ok;
                rsp_q_q  <= q_sel;
            end

            if (state == SETTLE && state_next == IDLE) in_init <= 1'b0;
        end
    end

`ifdef RSLATCH_SEQ_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_q <= 1'b0;
        end else if (state == IDLE && bus.cmd_valid) begin
            retry_q <= 1'b0;
        end else if (state == CHECK && state_next == APPLY) begin
            retry_q <= 1'b1;
        end
    end
`endif

    rslatch_seq_drv #(
        .NUM_LATCH (NUM_LATCH),
        .IDX_W     (IDX_W)
    ) u_drv (
        .clk      (clk),
        .rst      (rst),
        .idx      (drv_idx),
        .set      (drv_set),
        .clr      (!drv_set),
        .active   (drv_active),
        .clr_all  (drv_clr_all),
        .latch_s  (latch_s),
        .latch_r  (latch_r),
        .latch_en (latch_en)
    );

endmodule

// File: tb/tb_rslatch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rslatch_seq_ctrl
// Bench for rslatch_seq_ctrl with an 8-latch behavioural RS bank, IDX_W=4 so
// that out-of-range indices can be issued. Honours RSLATCH_SEQ_RETRY_EN.
// -----------------------------------------------------------------------------
module tb_rslatch_seq_ctrl;
    import rslatch_seq_pkg::*;

    localparam int NL       = 8;
    localparam int IW       = 4;
    localparam int PULSE    = 4;
    localparam int SETTLE   = 2;
    localparam int REAL_LAT = 1 + PULSE + SETTLE + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rslatch_seq_ctrl_if #(.IDX_W(IW)) bus ();

    logic [NL-1:0] latch_s, latch_r, latch_q, latch_nq;
    logic          latch_en;
    state_e        dbg_state;

    rslatch_seq_ctrl #(
        .NUM_LATCH  (NL),
        .IDX_W      (IW),
        .PULSE_CYC  (PULSE),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .latch_s   (latch_s),
        .latch_r   (latch_r),
        .latch_en  (latch_en),
        .latch_q   (latch_q),
        .latch_nq  (latch_nq),
        .dbg_state (dbg_state)
    );

    // ---------------- latch bank model ----------------
    logic [NL-1:0] bank_q = 8'hA5;
    logic [NL-1:0] stuck0 = 8'h00;

    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (latch_en && latch_s[i])      bank_q[i] <= 1'b1;
            else if (latch_en && latch_r[i]) bank_q[i] <= 1'b0;
        end
    end

    assign latch_q  = bank_q & ~stuck0;
    assign latch_nq = ~bank_q;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int overlap_cnt = 0;

    always @(negedge clk) begin
        if ((latch_s & latch_r) != '0) overlap_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        int            lat;
        logic          ok;
        logic          q;
        int            s_cyc;
        int            r_cyc;
        int            s_pulses;
        logic [NL-1:0] s_seen;
        logic [NL-1:0] r_seen;
    } result_t;

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge of the rsp_valid cycle.
    task automatic do_cmd(input logic [IW-1:0] idx, input logic [1:0] op, output result_t res);
        int  w = 0;
        logic prev_s = 1'b0;
        while (!bus.cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.cmd_ready) check("cmd_ready wait", 0, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_idx   = idx;
        bus.cmd_op    = op;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        res.lat = 1; res.s_cyc = 0; res.r_cyc = 0; res.s_pulses = 0;
        res.s_seen = '0; res.r_seen = '0;
        while (!bus.rsp_valid && res.lat < 100) begin
            if (latch_s != '0) res.s_cyc++;
            if (latch_r != '0) res.r_cyc++;
            if (latch_s != '0 && !prev_s) res.s_pulses++;
            prev_s = (latch_s != '0);
            res.s_seen |= latch_s;
            res.r_seen |= latch_r;
            @(negedge clk);
            res.lat++;
        end
        res.ok = bus.rsp_ok;
        res.q  = bus.rsp_q;
    endtask

    // Called at the negedge where rst has just been released.
    task automatic measure_init(input string tag);
        int r_ff = 0;
        int ready_at = 0;
        for (int n = 1; n <= 20 && ready_at == 0; n++) begin
            @(negedge clk);
            if (latch_r == 8'hFF) r_ff++;
            if (bus.cmd_ready) ready_at = n;
        end
        check({tag, " r_all_cycles"}, r_ff, PULSE);
        check({tag, " ready_cycle"}, ready_at, PULSE + SETTLE + 1);
        check({tag, " bank_cleared"}, int'(bank_q), 0);
        check({tag, " latch_en"}, int'(latch_en), 1);
        check({tag, " state_idle"}, int'(dbg_state), int'(IDLE));
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [IW-1:0] idx;
        logic [1:0]    op;
        logic          ok;
        logic          chk_q;
        logic          q;
        int            lat;
        logic [NL-1:0] s_mask;
        logic [NL-1:0] r_mask;
    } vec_t;

    vec_t vecs[13];

    initial begin
        result_t res;
        bus.cmd_valid = 1'b0;
        bus.cmd_idx   = '0;
        bus.cmd_op    = 2'b00;

        //            idx    op         ok  chkq q   lat       s_mask  r_mask
        vecs[0]  = '{4'd3,  OP_SET,    1, 1, 1, REAL_LAT, 8'h08, 8'h00};
        vecs[1]  = '{4'd3,  OP_CLR,    1, 1, 0, REAL_LAT, 8'h00, 8'h08};
        vecs[2]  = '{4'd3,  OP_TOGGLE, 1, 1, 1, REAL_LAT, 8'h08, 8'h00};
        vecs[3]  = '{4'd3,  OP_TOGGLE, 1, 1, 0, REAL_LAT, 8'h00, 8'h08};
        vecs[4]  = '{4'd9,  OP_SET,    0, 0, 0, 1,        8'h00, 8'h00};
        vecs[5]  = '{4'd2,  OP_NOP,    1, 0, 0, 1,        8'h00, 8'h00};
        vecs[6]  = '{4'd0,  OP_SET,    1, 1, 1, REAL_LAT, 8'h01, 8'h00};
        vecs[7]  = '{4'd7,  OP_SET,    1, 1, 1, REAL_LAT, 8'h80, 8'h00};
        vecs[8]  = '{4'd7,  OP_CLR,    1, 1, 0, REAL_LAT, 8'h00, 8'h80};
        vecs[9]  = '{4'd8,  OP_SET,    0, 0, 0, 1,        8'h00, 8'h00};
        vecs[10] = '{4'd15, OP_CLR,    0, 0, 0, 1,        8'h00, 8'h00};
        vecs[11] = '{4'd0,  OP_TOGGLE, 1, 1, 0, REAL_LAT, 8'h00, 8'h01};
        vecs[12] = '{4'd9,  OP_NOP,    0, 0, 0, 1,        8'h00, 8'h00};

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst cmd_ready", int'(bus.cmd_ready), 0);
        check("rst rsp_valid", int'(bus.rsp_valid), 0);
        check("rst rsp_ok",    int'(bus.rsp_ok), 0);
        check("rst rsp_q",     int'(bus.rsp_q), 0);
        check("rst latch_s",   int'(latch_s), 0);
        check("rst latch_r",   int'(latch_r), 0);
        check("rst latch_en",  int'(latch_en), 0);
        check("rst state",     int'(dbg_state), int'(INIT));
        rst = 1'b0;
        measure_init("init");

        // ---- table ----
        for (int i = 0; i < 13; i++) begin
            do_cmd(vecs[i].idx, vecs[i].op, res);
            check($sformatf("vec%0d latency", i), res.lat, vecs[i].lat);
            check($sformatf("vec%0d rsp_ok", i), int'(res.ok), int'(vecs[i].ok));
            if (vecs[i].chk_q) check($sformatf("vec%0d rsp_q", i), int'(res.q), int'(vecs[i].q));
            check($sformatf("vec%0d s_mask", i), int'(res.s_seen), int'(vecs[i].s_mask));
            check($sformatf("vec%0d r_mask", i), int'(res.r_seen), int'(vecs[i].r_mask));
            check($sformatf("vec%0d s_cycles", i), res.s_cyc, (vecs[i].s_mask != '0) ? PULSE : 0);
            check($sformatf("vec%0d r_cycles", i), res.r_cyc, (vecs[i].r_mask != '0) ? PULSE : 0);
            @(negedge clk);
            check($sformatf("vec%0d rsp_valid_drop", i), int'(bus.rsp_valid), 0);
        end

        // ---- stuck-at-0 readback on latch 5 ----
        stuck0 = 8'h20;
        do_cmd(4'd5, OP_SET, res);
        check("stuck rsp_ok", int'(res.ok), 0);
        check("stuck rsp_q",  int'(res.q), 0);
`ifdef RSLATCH_SEQ_RETRY_EN
        check("stuck latency",  res.lat, 2 * REAL_LAT - 1);
        check("stuck s_cycles", res.s_cyc, 2 * PULSE);
        check("stuck s_pulses", res.s_pulses, 2);
`else
        check("stuck latency",  res.lat, REAL_LAT);
        check("stuck s_cycles", res.s_cyc, PULSE);
        check("stuck s_pulses", res.s_pulses, 1);
`endif
        @(negedge clk);
        stuck0 = 8'h00;

        // ---- reset in the middle of APPLY ----
        begin
            int w = 0;
            while (!bus.cmd_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            bus.cmd_valid = 1'b1;
            bus.cmd_idx   = 4'd1;
            bus.cmd_op    = OP_SET;
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            @(negedge clk);
            check("mid apply latch_s", int'(latch_s), 8'h02);
            rst = 1'b1;
            @(negedge clk);
            check("mid rst latch_s",   int'(latch_s), 0);
            check("mid rst cmd_ready", int'(bus.cmd_ready), 0);
            check("mid rst latch_en",  int'(latch_en), 0);
            check("mid rst state",     int'(dbg_state), int'(INIT));
            rst = 1'b0;
            measure_init("reinit");
        end

        // ---- one more real op after re-init ----
        do_cmd(4'd6, OP_TOGGLE, res);
        check("post toggle rsp_ok", int'(res.ok), 1);
        check("post toggle rsp_q",  int'(res.q), 1);
        check("post toggle s_mask", int'(res.s_seen), 8'h40);

        check("no s/r overlap", overlap_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time bound in case a wait is ever broken.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
